// File: rtl/outfifo_serial_tx.sv
// Drains the output FIFO and shifts each word onto one pad line with UART-style
// framing: a start bit (0), DATA_W data bits LSB first, then a stop bit (1).
module outfifo_serial_tx #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              inClock,
    input  logic              inReset,
    input  logic              inTxEnable,
    input  logic              inFifoEmpty,
    input  logic [DATA_W-1:0] inFifoData,
    output logic              outFifoReadEnable,
    output logic              outSerial,
    output logic              outBusy,
    output logic [CNT_W-1:0]  outFrameCount
);

    localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               serial_q, serial_d;
    logic               ren_q, ren_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               go_c;
    logic               bit_end_c;

    assign go_c      = inTxEnable && !inFifoEmpty;
    assign bit_end_c = (cyc_q == CYC_LAST);

    // Next-state logic; outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (go_c) state_d = S_POP;
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shift_d = inFifoData;
                cyc_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (bit_end_c) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    cyc_d   = '0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = go_c ? S_POP : S_IDLE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ren_d  = (state_d == S_POP);
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            ren_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            ren_q    <= ren_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign outFifoReadEnable = ren_q;
    assign outSerial         = serial_q;
    assign outBusy           = busy_q;
    assign outFrameCount     = cnt_q;

endmodule

// File: tb/tb_outfifo_serial_tx.sv
// Scoreboard bench: a FIFO model feeds the selected DUT, expected frames are queued at
// push time, and a negedge monitor decodes the serial line against them.
module tb_outfifo_serial_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en;
    logic       fifo_empty;
    logic [3:0] fifo_data;
    logic       sel;

    logic       en0, emp0, ren0, ser0, busy0;
    logic       en1, emp1, ren1, ser1, busy1;
    logic [7:0] cnt0, cnt1;

    assign en0  = !sel && en;
    assign emp0 = sel || fifo_empty;
    assign en1  = sel && en;
    assign emp1 = !sel || fifo_empty;

    outfifo_serial_tx #(.DATA_W(4), .BIT_CYCLES(4), .CNT_W(8)) dut0 (
        .inClock(clk), .inReset(rst_n), .inTxEnable(en0), .inFifoEmpty(emp0),
        .inFifoData(fifo_data), .outFifoReadEnable(ren0), .outSerial(ser0),
        .outBusy(busy0), .outFrameCount(cnt0)
    );

    outfifo_serial_tx #(.DATA_W(4), .BIT_CYCLES(1), .CNT_W(8)) dut1 (
        .inClock(clk), .inReset(rst_n), .inTxEnable(en1), .inFifoEmpty(emp1),
        .inFifoData(fifo_data), .outFifoReadEnable(ren1), .outSerial(ser1),
        .outBusy(busy1), .outFrameCount(cnt1)
    );

    logic       ren_m, ser_m, busy_m;
    logic [7:0] cnt_m;
    int         bc_m;
    assign ren_m  = sel ? ren1 : ren0;
    assign ser_m  = sel ? ser1 : ser0;
    assign busy_m = sel ? busy1 : busy0;
    assign cnt_m  = sel ? cnt1 : cnt0;
    assign bc_m   = sel ? 1 : 4;

    logic [3:0] fifo_q[$];
    logic [5:0] exp_q[$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Monitor state
    bit         active = 1'b0;
    bit         pend   = 1'b0;
    bit         dec    = 1'b1;
    bit         go_s   = 1'b0;
    int         t      = 0;
    int         line_err = 0;
    int         frames_done = 0;
    logic [5:0] frame = '0;
    logic [7:0] model_cnt = '0;

    // Snapshot what the DUT sees at a decision edge.
    always @(posedge clk) go_s = dec && rst_n && en && !fifo_empty;

    always @(negedge clk) begin
        if (!rst_n) begin
            active    = 1'b0;
            pend      = 1'b0;
            dec       = 1'b1;
            model_cnt = '0;
        end else if (!active) begin
            chk("pop_decision", 32'({ren_m, busy_m, ser_m}), 32'({go_s, go_s, 1'b1}));
            if (pend) begin
                chk("frame_count", 32'(cnt_m), 32'(model_cnt));
                pend = 1'b0;
            end
            if (ren_m) begin
                chk("no_underflow", 32'(fifo_q.size() > 0), 32'd1);
                if (fifo_q.size() > 0) begin
                    fifo_data  = fifo_q.pop_front();
                    fifo_empty = (fifo_q.size() == 0);
                end
                chk("scoreboard_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) frame = exp_q.pop_front();
                else frame = 6'h3f;
                active   = 1'b1;
                t        = 0;
                line_err = 0;
                dec      = 1'b0;
            end else begin
                dec = 1'b1;
            end
        end else begin
            logic [5:0] tmp;
            logic       exp_bit;
            t++;
            if (ren_m || !busy_m) line_err++;
            if (t == 1) begin
                exp_bit = 1'b1;
            end else begin
                tmp     = frame >> ((t - 2) / bc_m);
                exp_bit = tmp[0];
            end
            if (ser_m !== exp_bit) line_err++;
            if (t == 2 + 6 * bc_m - 1) begin
                chk("frame_line", 32'(line_err), 32'd0);
                model_cnt++;
                frames_done++;
                pend   = 1'b1;
                active = 1'b0;
                dec    = 1'b1;
            end else begin
                dec = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] w);
        fifo_q.push_back(w);
        exp_q.push_back({1'b1, w, 1'b0});
        fifo_empty = 1'b0;
    endtask

    task automatic do_reset(input logic s);
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = s;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        step(3);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input bit need_empty, input string name);
        int n = 0;
        while (n < budget && (active || busy_m || (need_empty && fifo_q.size() > 0))) begin
            step(1);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_t(input int target, input int budget, input string name);
        int n = 0;
        while (n < budget && !(active && t == target)) begin
            step(1);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0;
        int np;
        rst_n      = 1'b0;
        en         = 1'b0;
        sel        = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;

        // Reset state, then an empty FIFO must never be popped
        step(1);
        chk("reset_ren", 32'(ren0), 32'd0);
        chk("reset_serial", 32'(ser0), 32'd1);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_count", 32'(cnt0), 32'd0);
        step(2);
        en    = 1'b1;
        rst_n = 1'b1;
        step(20);
        chk("empty_idle_busy", 32'(busy0), 32'd0);
        chk("empty_idle_serial", 32'(ser0), 32'd1);
        chk("empty_idle_count", 32'(cnt0), 32'd0);

        // Single frame 4'b1011
        do_reset(1'b0);
        f0 = frames_done;
        en = 1'b1;
        push(4'b1011);
        wait_idle(100, 1'b1, "single_done");
        chk("single_count", 32'(cnt_m), 32'd1);
        chk("single_frames", 32'(frames_done - f0), 32'd1);

        // Back-to-back frames
        do_reset(1'b0);
        push(4'hA);
        push(4'h5);
        en = 1'b1;
        wait_idle(200, 1'b1, "b2b_done");
        chk("b2b_count", 32'(cnt_m), 32'd2);

        // Enable drop during DATA of the first of three queued words
        do_reset(1'b0);
        push(4'($urandom));
        push(4'($urandom));
        push(4'($urandom));
        en = 1'b1;
        wait_t(6, 50, "drop_reach_data");
        en = 1'b0;
        wait_idle(100, 1'b0, "drop_done");
        step(10);
        chk("drop_count", 32'(cnt_m), 32'd1);
        chk("drop_busy", 32'(busy_m), 32'd0);
        chk("drop_fifo_left", 32'(fifo_q.size()), 32'd2);

        // Asynchronous reset during the second data bit
        do_reset(1'b0);
        en = 1'b1;
        push(4'($urandom));
        wait_idle(100, 1'b1, "pre_abort_done");
        chk("pre_abort_count", 32'(cnt_m), 32'd1);
        push(4'b1101);
        push(4'($urandom));
        wait_t(11, 100, "abort_reach_bit1");
        #1;
        chk("pre_reset_serial", 32'(ser_m), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_serial", 32'(ser_m), 32'd1);
        chk("async_reset_busy", 32'(busy_m), 32'd0);
        chk("async_reset_count", 32'(cnt_m), 32'd0);
        step(2);
        rst_n = 1'b1;
        wait_idle(100, 1'b1, "post_abort_done");
        chk("post_abort_count", 32'(cnt_m), 32'd1);

        // Random pushes with random enable toggling
        do_reset(1'b0);
        f0 = frames_done;
        np = 0;
        repeat (60) begin
            step($urandom_range(1, 12));
            case ($urandom_range(0, 3))
                0, 1: begin
                    push(4'($urandom));
                    np++;
                end
                2: en = ~en;
                default: ;
            endcase
        end
        en = 1'b1;
        wait_idle(3000, 1'b1, "random_done");
        chk("random_frames", 32'(frames_done - f0), 32'(np));

        // Counter wrap with one clock per bit
        do_reset(1'b1);
        f0 = frames_done;
        for (int i = 0; i < 257; i++) push(4'($urandom));
        en = 1'b1;
        wait_idle(257 * 8 + 100, 1'b1, "wrap_done");
        chk("wrap_frames", 32'(frames_done - f0), 32'd257);
        chk("wrap_count", 32'(cnt_m), 32'd1);

        step(2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
